// File: rtl/i2c_master.sv
// I2C register-access master: single-byte register write, or register read
// using a repeated START. SCL runs at 4*DIV system clocks per bit slot.
module i2c_master #(
    parameter int DIV = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       SDA,
    output logic       SCL,
    output logic       SDA_out,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;     // 0: address+W, 1: register, 2: data or address+R
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;        // read shadow; copied to rd_data only on success
    logic       ack_bit;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wd_q;
    logic       sda_meta;
    logic       sda_sync;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte2;

    // Bytes the master transmits, in order; the third depends on direction.
    assign byte0 = {dev_q, 1'b0};
    assign byte1 = reg_q;
    assign byte2 = rw_q ? {dev_q, 1'b1} : wd_q;

    // Bus pin levels {SCL, SDA_out} for a given state and quarter.
    // pre selects the SCL-low lead-in slot that precedes a repeated START.
    function automatic logic [1:0] pins(state_t st, logic [1:0] q, logic tx_bit, logic pre);
        logic [1:0] p;
        // NOTE: default arm keeps the function total, so no path infers storage.
        case (st)
            START:                   p = {q != 2'd3, ~q[1]};
            RESTART:                 p = pre ? 2'b01 : {q != 2'd3, ~q[1]};
            TX_BYTE:                 p = {q[1], tx_bit};
            RX_ACK, RX_BYTE, TX_NACK: p = {q[1], 1'b1};
            STOP:                    p = {q[1], q == 2'd3};
            default:                 p = 2'b11;
        endcase
        return p;
    endfunction

    // Two-flop synchronizer on the incoming SDA level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking (<=) for every flop so all registers update together at the edge.
            sda_meta <= SDA;
            sda_sync <= sda_meta;
        end
    end

    // Transaction FSM: quarter timing, bit/byte sequencing and registered pin drive.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            quarter  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            ack_bit  <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wd_q     <= '0;
            SCL      <= 1'b1;
            SDA_out  <= 1'b1;
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                // A go coinciding with the done pulse is dropped.
                if (go && !done) begin
                    rw_q     <= rw;
                    dev_q    <= dev_addr;
                    reg_q    <= reg_addr;
                    wd_q     <= wr_data;
                    nack     <= 1'b0;
                    busy     <= 1'b1;
                    byte_idx <= 2'd0;
                    state    <= START;
                end
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= '0;
                // Last cycle of Q2: SCL has been high for a full quarter.
                if (quarter == 2'd2) begin
                    ack_bit <= sda_sync;
                    if (state == RX_BYTE)
                        rx_sr <= {rx_sr[6:0], sda_sync};
                end
                if (quarter != 2'd3) begin
                    quarter <= quarter + 2'd1;
                    {SCL, SDA_out} <= pins(state, quarter + 2'd1, tx_sr[7], bit_cnt == 3'd0);
                end else begin
                    quarter <= 2'd0;
                    case (state)
                        START: begin
                            tx_sr          <= byte0;
                            state          <= TX_BYTE;
                            {SCL, SDA_out} <= pins(TX_BYTE, 2'd0, byte0[7], 1'b0);
                        end
                        TX_BYTE: begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt        <= 3'd0;
                                state          <= RX_ACK;
                                {SCL, SDA_out} <= 2'b01;
                            end else begin
                                bit_cnt        <= bit_cnt + 3'd1;
                                tx_sr          <= {tx_sr[6:0], 1'b0};
                                {SCL, SDA_out} <= pins(TX_BYTE, 2'd0, tx_sr[6], 1'b0);
                            end
                        end
                        RX_ACK: begin
                            if (ack_bit) begin
                                nack           <= 1'b1;
                                state          <= STOP;
                                {SCL, SDA_out} <= 2'b00;
                            end else begin
                                case (byte_idx)
                                    2'd0: begin
                                        byte_idx       <= 2'd1;
                                        tx_sr          <= byte1;
                                        state          <= TX_BYTE;
                                        {SCL, SDA_out} <= pins(TX_BYTE, 2'd0, byte1[7], 1'b0);
                                    end
                                    2'd1: begin
                                        if (rw_q) begin
                                            state          <= RESTART;
                                            {SCL, SDA_out} <= 2'b01;
                                        end else begin
                                            byte_idx       <= 2'd2;
                                            tx_sr          <= byte2;
                                            state          <= TX_BYTE;
                                            {SCL, SDA_out} <= pins(TX_BYTE, 2'd0, byte2[7], 1'b0);
                                        end
                                    end
                                    default: begin
                                        state          <= rw_q ? RX_BYTE : STOP;
                                        {SCL, SDA_out} <= rw_q ? 2'b01 : 2'b00;
                                    end
                                endcase
                            end
                        end
                        RESTART: begin
                            if (bit_cnt == 3'd0) begin
                                bit_cnt        <= 3'd1;
                                {SCL, SDA_out} <= pins(RESTART, 2'd0, 1'b1, 1'b0);
                            end else begin
                                bit_cnt        <= 3'd0;
                                byte_idx       <= 2'd2;
                                tx_sr          <= byte2;
                                state          <= TX_BYTE;
                                {SCL, SDA_out} <= pins(TX_BYTE, 2'd0, byte2[7], 1'b0);
                            end
                        end
                        RX_BYTE: begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                state   <= TX_NACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                            {SCL, SDA_out} <= 2'b01;
                        end
                        TX_NACK: begin
                            state          <= STOP;
                            {SCL, SDA_out} <= 2'b00;
                        end
                        STOP: begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            {SCL, SDA_out} <= 2'b11;
                            if (rw_q && !nack)
                                rd_data <= rx_sr;
                        end
                        default: begin
                            state          <= IDLE;
                            {SCL, SDA_out} <= 2'b11;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a behavioural I2C target at address 7'h20.
// Bytes seen on the bus are checked against a queue of expected bytes.
module tb_i2c_master;

    localparam int DIV  = 4;
    localparam int SLOT = 4 * DIV;
    localparam logic [6:0] TGT = 7'h20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0;
    logic [7:0] wr_data = '0;
    logic       SDA;
    logic       SCL;
    logic       SDA_out;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       nack;

    logic       tgt_low = 1'b0;
    assign SDA = SDA_out & ~tgt_low;

    i2c_master #(.DIV(DIV)) dut (
        .clock   (clock),
        .reset   (reset),
        .go      (go),
        .rw      (rw),
        .dev_addr(dev_addr),
        .reg_addr(reg_addr),
        .wr_data (wr_data),
        .SDA     (SDA),
        .SCL     (SCL),
        .SDA_out (SDA_out),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .nack    (nack)
    );

    always #5 clock = ~clock;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         starts = 0;
    int         stops = 0;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Target model state
    int         bit_n = 0;
    logic [7:0] sh = '0;
    logic [7:0] snd = '0;
    logic [7:0] tgt_data = 8'h3C;
    logic       first_byte = 1'b0;
    logic       addressed = 1'b0;
    logic       rd_mode = 1'b0;
    logic       sending = 1'b0;
    logic       mack = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    // Bus observer and target: detects START/STOP, shifts bits on SCL rise,
    // drives ACK and read data on SCL fall.
    always @(negedge clock) begin
        logic sda_now;
        logic [31:0] e;
        sda_now = SDA_out & ~tgt_low;
        if (done) done_cnt++;
        if (reset) begin
            bit_n = 0; tgt_low = 1'b0; sending = 1'b0; addressed = 1'b0; first_byte = 1'b0;
        end else if (SCL && scl_p && sda_p && !sda_now) begin
            starts++; bit_n = 0; first_byte = 1'b1; sending = 1'b0; tgt_low = 1'b0;
        end else if (SCL && scl_p && !sda_p && sda_now) begin
            stops++; addressed = 1'b0; sending = 1'b0; tgt_low = 1'b0;
        end else if (SCL && !scl_p) begin
            if (bit_n < 8) begin
                sh = {sh[6:0], sda_now};
                bit_n++;
            end else if (bit_n == 8) begin
                mack = sda_now;
                bit_n = 9;
            end
        end else if (!SCL && scl_p) begin
            if (bit_n == 8) begin
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
                check("bus_byte", 32'(sh), e);
                if (first_byte) begin
                    addressed  = (sh[7:1] == TGT);
                    rd_mode    = sh[0];
                    first_byte = 1'b0;
                    tgt_low    = addressed;
                end else begin
                    tgt_low = addressed && !sending;
                end
            end else if (bit_n == 9) begin
                bit_n   = 0;
                tgt_low = 1'b0;
                if (addressed && rd_mode && !sending) begin
                    sending = 1'b1;
                    snd     = tgt_data;
                    tgt_low = ~snd[7];
                end
            end else if (sending && bit_n >= 1 && bit_n <= 7) begin
                snd     = {snd[6:0], 1'b0};
                tgt_low = ~snd[7];
            end
        end
        scl_p = SCL;
        sda_p = SDA_out & ~tgt_low;
    end

    task automatic launch(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clock);
        rw = r; dev_addr = d; reg_addr = ra; wr_data = wd; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        check("busy_after_go", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, p, dc;

        // Reset state while reset is held
        repeat (3) @(negedge clock);
        check("rst_scl", 32'(SCL), 32'd1);
        check("rst_sda", 32'(SDA_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_rd", 32'(rd_data), 32'h00);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Register write, target ACKs everything
        exp_q.push_back(8'h40); exp_q.push_back(8'h01); exp_q.push_back(8'hA5);
        s = starts; p = stops;
        launch(1'b0, 7'h20, 8'h01, 8'hA5);
        wait_done(n);
        check("wr_nack", 32'(nack), 32'd0);
        check("wr_len", 32'(n >= 29*SLOT - DIV && n <= 29*SLOT + DIV), 32'd1);
        @(negedge clock);
        check("wr_done_pulse", 32'(done), 32'd0);
        check("wr_bytes_left", 32'(exp_q.size()), 32'd0);
        check("wr_starts", 32'(starts - s), 32'd1);
        check("wr_stops", 32'(stops - p), 32'd1);

        // Register read via repeated START
        exp_q.push_back(8'h40); exp_q.push_back(8'h03); exp_q.push_back(8'h41); exp_q.push_back(8'h3C);
        s = starts; p = stops;
        launch(1'b1, 7'h20, 8'h03, 8'h00);
        wait_done(n);
        check("rd_data", 32'(rd_data), 32'h3C);
        check("rd_nack", 32'(nack), 32'd0);
        check("rd_master_nack_bit", 32'(mack), 32'd1);
        @(negedge clock);
        check("rd_bytes_left", 32'(exp_q.size()), 32'd0);
        check("rd_starts", 32'(starts - s), 32'd2);
        check("rd_stops", 32'(stops - p), 32'd1);

        // Unknown address: target never ACKs
        exp_q.push_back(8'h42);
        s = starts; p = stops;
        launch(1'b0, 7'h21, 8'h55, 8'h66);
        wait_done(n);
        check("nack_flag", 32'(nack), 32'd1);
        check("nack_len", 32'(n >= 11*SLOT - DIV && n <= 11*SLOT + DIV), 32'd1);
        check("nack_rd_hold", 32'(rd_data), 32'h3C);
        // go in the done cycle must be dropped
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        check("go_at_done_busy", 32'(busy), 32'd0);
        check("nack_held", 32'(nack), 32'd1);
        repeat (2 * SLOT) @(negedge clock);
        check("nack_bytes_left", 32'(exp_q.size()), 32'd0);
        check("nack_stops", 32'(stops - p), 32'd1);

        // go pulsed mid-transaction with different inputs
        exp_q.push_back(8'h40); exp_q.push_back(8'h01); exp_q.push_back(8'hA5);
        dc = done_cnt;
        launch(1'b0, 7'h20, 8'h01, 8'hA5);
        repeat (100) @(negedge clock);
        rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'hFF; wr_data = 8'h00; go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        wait_done(n);
        check("midgo_nack", 32'(nack), 32'd0);
        repeat (2 * SLOT) @(negedge clock);
        check("midgo_one_done", 32'(done_cnt - dc), 32'd1);
        check("midgo_idle", 32'(busy), 32'd0);
        check("midgo_bytes_left", 32'(exp_q.size()), 32'd0);
        check("midgo_rd_hold", 32'(rd_data), 32'h3C);

        // Reset during TX_BYTE bit 4 (second quarter, SCL low)
        exp_q.push_back(8'h40); exp_q.push_back(8'h01); exp_q.push_back(8'hA5);
        dc = done_cnt;
        launch(1'b0, 7'h20, 8'h01, 8'hA5);
        repeat (5*SLOT + DIV + 1) @(negedge clock);
        check("pre_abort_scl_low", 32'(SCL), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_scl", 32'(SCL), 32'd1);
        check("abort_sda", 32'(SDA_out), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("abort_rd_cleared", 32'(rd_data), 32'h00);
        repeat (30 * SLOT) @(negedge clock);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        // Fresh write after abort
        exp_q.push_back(8'h40); exp_q.push_back(8'h01); exp_q.push_back(8'hA5);
        s = starts; p = stops;
        launch(1'b0, 7'h20, 8'h01, 8'hA5);
        wait_done(n);
        check("post_nack", 32'(nack), 32'd0);
        check("post_len", 32'(n >= 29*SLOT - DIV && n <= 29*SLOT + DIV), 32'd1);
        @(negedge clock);
        check("post_bytes_left", 32'(exp_q.size()), 32'd0);
        check("post_starts", 32'(starts - s), 32'd1);
        check("post_stops", 32'(stops - p), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter DIV, default 25: clock cycles per SCL quarter-period; SCL period = 4*DIV cycles; legal range 4..255.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 go  input  1  transaction request; sampled only in IDLE.
REQ-005 rw  input  1  0 = register write, 1 = register read; captured with go.
REQ-006 dev_addr  input  7  target address; captured with go.
REQ-007 reg_addr  input  8  target register index; captured with go.
REQ-008 wr_data  input  8  write byte; captured with go.
REQ-009 SDA  input  1  bus SDA level as seen by the block.
REQ-010 SCL  output  1  bus clock; 1 = released/high.
REQ-011 SDA_out  output  1  open-drain SDA drive; 0 = pull low, 1 = release.
REQ-012 rd_data  output  8  byte returned by a read; held until the next read completes.
REQ-013 busy  output  1  high from the cycle after go is accepted until done.
REQ-014 done  output  1  one-cycle pulse at transaction end.
REQ-015 nack  output  1  valid with done: 1 = target failed to ACK; held until next go is accepted.

Function
REQ-016 SDA passes through a 2-flop synchronizer before any use.
REQ-017 States: IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP.
REQ-018 IDLE: SCL=1, SDA_out=1, busy=0; go=1 captures rw/dev_addr/reg_addr/wr_data and enters START.
REQ-019 go while busy is ignored; no queueing.
REQ-020 Bit slot = 4 quarters Q0..Q3: SCL=0 in Q0/Q1, SCL=1 in Q2/Q3; SDA_out changes only at start of Q0.
REQ-021 Read bits (ACK, data) sample the synchronized SDA in the last cycle of Q2.
REQ-022 START: Q0/Q1 SCL=1, SDA_out=1; Q2 SDA_out=0 with SCL=1; Q3 SCL=0.
REQ-023 RESTART: identical to START, preceded by SDA_out=1 while SCL=0.
REQ-024 TX_BYTE shifts 8 bits MSB first; RX_BYTE shifts 8 bits MSB first into rd_data shadow with SDA_out=1.
REQ-025 RX_ACK releases SDA for one bit slot; sampled 0 = ACK, 1 = NACK.
REQ-026 Write sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, wr_data, ACK, STOP.
REQ-027 Read sequence: START, {dev_addr,0}, ACK, reg_addr, ACK, RESTART, {dev_addr,1}, ACK, RX_BYTE, TX_NACK (SDA_out=1 one slot), STOP.
REQ-028 Any NACK sets nack=1 and goes directly to STOP; remaining bytes are not sent; rd_data unchanged.
REQ-029 STOP: Q0/Q1 SCL=0, SDA_out=0; Q2 SCL=1; Q3 SDA_out=1; then done=1 for one cycle, busy=0, IDLE.
REQ-030 rd_data updates only on successful read completion, same cycle as done.
REQ-031 Bit counter 0..7, quarter counter 0..3, divider 0..DIV-1; all wrap to 0, no overflow beyond range.
REQ-032 go asserted in the same cycle as done is ignored; a new go is accepted from the next cycle.

Reset
REQ-033 reset asserted: immediately SCL=1, SDA_out=1, busy=0, done=0, nack=0, rd_data=8'h00, state IDLE, all counters 0.
REQ-034 reset mid-transaction aborts without issuing STOP; no done pulse; next go starts a fresh transaction.

Verification
REQ-035 Write dev 7'h20, reg 8'h01, data 8'hA5, target ACKs all -> SDA bytes 8'h40, 8'h01, 8'hA5 MSB first; done=1, nack=0; transaction lasts (29 slots)*4*DIV cycles +/-1 quarter.
REQ-036 Read dev 7'h20, reg 8'h03, target returns 8'h3C -> bytes 8'h40, 8'h03, RESTART, 8'h41; rd_data=8'h3C with done; master NACK bit is 1.
REQ-037 Write dev 7'h21, target leaves SDA released -> STOP after first ACK slot; done=1, nack=1; reg_addr never driven.
REQ-038 go pulsed mid-transaction with different inputs -> ignored; original bytes sent unchanged; exactly one done.
REQ-039 reset asserted during TX_BYTE bit 4 -> same cycle SCL=1, SDA_out=1, busy=0; no done; subsequent write completes correctly.
REQ-040 START/STOP check: SDA_out transitions while SCL=1 only at START, RESTART, STOP; never during data bits.
